// File: rtl/muldiv_sequencer_pkg.sv
// Shared decode constants, FSM encodings and funct helpers for the mult/div sequencer.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package muldiv_sequencer_pkg;

    localparam logic [3:0] RTYPE_OP    = 4'h2;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t ITER = 2'd1;
    localparam state_t FIX  = 2'd2;

    function automatic logic is_muldiv_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

    function automatic logic is_signed_funct(input logic [5:0] f);
        return (f == FUNCT_MULT) || (f == FUNCT_DIV);
    endfunction

    function automatic logic is_div_funct(input logic [5:0] f);
        return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath with operand magnitude and sign correction.
// Latency: one step per step strobe; corrected result is combinational from the accumulator.
// Backpressure: none, the sequencer owns all pacing through load/step.
module muldiv_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             signed_op,
    input  logic             div_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
`ifdef MULDIV_EARLY_OUT_EN
    input  logic [CW-1:0]    cnt,
    output logic             early,
`endif
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opb;
    logic               op_div, neg_q, neg_rem, b_zero;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;

    assign a_neg = signed_op & rs_val[WIDTH-1];
    assign b_neg = signed_op & rt_val[WIDTH-1];
    // The most-negative value negates to itself, which read unsigned is the correct magnitude.
    assign abs_a = a_neg ? -rs_val : rs_val;
    assign abs_b = b_neg ? -rt_val : rt_val;

    logic [WIDTH:0]     sum, sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {sum, acc[WIDTH-1:1]};
        sh       = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = sh - {1'b0, opb};
        div_next = {(diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]), acc[WIDTH-2:0], ~diff[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            opb     <= '0;
            op_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
        end else if (load) begin
            acc     <= {{WIDTH{1'b0}}, (div_op ? abs_a : abs_b)};
            opb     <= div_op ? abs_b : abs_a;
            op_div  <= div_op;
            neg_q   <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            b_zero  <= (rt_val == '0);
        end else if (step) begin
            acc     <= op_div ? div_next : mul_next;
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   q, r;

`ifdef MULDIV_EARLY_OUT_EN
    // Bits [cnt-1:0] of the next lower half are the multiplier bits not yet consumed.
    logic [WIDTH-1:0] rest_mask;
    assign rest_mask = (WIDTH'(1) << cnt) - WIDTH'(1);
    assign early     = ~op_div & ((mul_next[WIDTH-1:0] & rest_mask) == '0);
    assign prod      = acc >> cnt;
`else
    assign prod      = acc;
`endif

    assign q = acc[WIDTH-1:0];
    assign r = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        {res_hi, res_lo} = neg_q ? -prod : prod;
        if (op_div) begin
            if (b_zero) begin
                res_hi = r;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -r : r;
                res_lo = neg_q ? -q : q;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage mult/div sequencer owning HI/LO; optional MULDIV_EARLY_OUT_EN ends multiplies once the multiplier is exhausted.
// Latency: issue at edge E, busy E+1..E+WIDTH+1, HI/LO and done in cycle E+WIDTH+2.
// Backpressure: stall is raised combinationally when a mult/div/mfhi/mflo meets an op in flight.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int         WIDTH        = 32,
    parameter logic [3:0] RTYPE_OPCODE = RTYPE_OP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [3:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_rtype, is_md, is_mfhi, is_mflo, accept, early;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign is_rtype = (opcode == RTYPE_OPCODE);
    assign is_md    = is_rtype & is_muldiv_funct(funct);
    assign is_mfhi  = is_rtype & (funct == FUNCT_MFHI);
    assign is_mflo  = is_rtype & (funct == FUNCT_MFLO);

    assign busy    = (state != IDLE);
    assign stall   = issue_valid & busy & (is_md | is_mfhi | is_mflo);
    assign mf_data = is_mfhi ? hi : (is_mflo ? lo : '0);
    // A flushed issue slot never starts an op, even from IDLE.
    assign accept  = (state == IDLE) & issue_valid & is_md & ~flush;

    muldiv_datapath #(.WIDTH(WIDTH), .CW(CW)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      ((state == ITER) & ~flush),
        .signed_op (is_signed_funct(funct)),
        .div_op    (is_div_funct(funct)),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
`ifdef MULDIV_EARLY_OUT_EN
        .cnt       (cnt),
        .early     (early),
`endif
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

`ifndef MULDIV_EARLY_OUT_EN
    assign early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ITER;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                ITER: begin
                    // cnt is left untouched on exit so the datapath can realign an early-out product.
                    if (flush)
                        state <= IDLE;
                    else if ((cnt == '0) || early)
                        state <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer in its default fixed-latency build.
// Latency: all ops checked for done exactly WIDTH+2 cycles after issue.
// Backpressure: checks stall against a pending mflo and flush/reset abort behaviour.
module tb_muldiv_sequencer;

    localparam int         WIDTH = 32;
    localparam logic [3:0] RT    = 4'h2;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
    localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [3:0]       opcode = 4'h0;
    logic [5:0]       funct = 6'h00;
    logic [WIDTH-1:0] rs_val = '0;
    logic [WIDTH-1:0] rt_val = '0;
    logic             flush = 1'b0;
    logic             stall, busy, done;
    logic [WIDTH-1:0] mf_data, hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(WIDTH), .RTYPE_OPCODE(RT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .opcode      (opcode),
        .funct       (funct),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .mf_data     (mf_data),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns in cycle E+1 (negedge), E being the accepting posedge.
    task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        issue_valid = 1'b1; opcode = RT; funct = f; rs_val = a; rt_val = b;
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo);
        int cyc;
        issue(f, a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 34);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int pulses;

        repeat (2) @(negedge clk);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall, 0);
        check("rst_mf_data", mf_data, 0);
        rst_n = 1'b1;

        // Non-muldiv funct and non-RTYPE opcode must not start anything.
        issue(6'h20, 32'd5, 32'd6);
        check("ign_funct_busy", busy, 0);
        @(negedge clk);
        issue_valid = 1'b1; opcode = 4'h0; funct = F_MULT;
        @(negedge clk);
        issue_valid = 1'b0;
        check("ign_opcode_busy", busy, 0);

        run_op("mult_neg3x7", F_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", F_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_minneg", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // mflo colliding with div 100/7 from cycle E+5.
        issue(F_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        issue_valid = 1'b1; opcode = RT; funct = F_MFLO;
        #1;
        for (int k = 5; k <= 33; k++) begin
            check($sformatf("mflo_stall_c%0d", k), stall, 1);
            @(negedge clk);
        end
        check("mflo_stall_release", stall, 0);
        check("mflo_done", done, 1);
        check("mflo_data", mf_data, 14);
        funct = F_MFHI;
        #1;
        check("mfhi_data", mf_data, 2);
        issue_valid = 1'b0; funct = 6'h00;

        // flush at E+12, then a fresh mult in the cycle busy drops.
        issue(F_MULT, 32'd5, 32'd6);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_hi", hi, 2);
        check("flush_lo", lo, 14);
        issue_valid = 1'b1; opcode = RT; funct = F_MULT; rs_val = 32'd9; rt_val = 32'hFFFF_FFFC;
        @(negedge clk);
        issue_valid = 1'b0; funct = 6'h00;
        check("reissue_busy", busy, 1);
        wait_done(cyc);
        check("reissue_latency", cyc, 34);
        check("reissue_hi", hi, 32'hFFFF_FFFF);
        check("reissue_lo", lo, 32'hFFFF_FFDC);

        // flush alongside an issue in IDLE blocks acceptance.
        @(negedge clk);
        issue_valid = 1'b1; opcode = RT; funct = F_MULT; flush = 1'b1;
        @(negedge clk);
        issue_valid = 1'b0; flush = 1'b0; funct = 6'h00;
        check("idle_flush_busy", busy, 0);

        // Async reset at E+10 of a mult.
        issue(F_MULT, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("arst_no_done", pulses, 0);
        check("arst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
